// File: rtl/multdiv_arbiter.sv
// multdiv_arbiter: shares one multdiv unit between two requesters.
// Round-robin grant, operand latching, one-cycle start pulse, wait for
// resultRDY with timeout, then a one-cycle response pulse to the winner.
//
// Handshake: a requester raises reqN_valid with stable operands and holds it
// until reqN_ready is seen high; the op is transferred in the cycle where
// valid && ready are both high. reqN_ready is only ever high in IDLE.
// Responses are a single-cycle respN_valid pulse with no back-pressure.
module multdiv_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_is_div,
    input  logic [31:0] req0_opA,
    input  logic [31:0] req0_opB,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_is_div,
    input  logic [31:0] req1_opA,
    input  logic [31:0] req1_opB,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [31:0] resp_result,
    output logic        resp_exception,
    output logic        resp_timeout,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Last WAIT cycle index: the counter reads 0..TIMEOUT_CYCLES-1 while waiting.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic              rr_ptr;
    logic              grant_id;
    logic              grant_nxt;
    logic              accept;
    logic              op_is_div;
    logic [31:0]       op_a;
    logic [31:0]       op_b;
    logic [CNT_W-1:0]  wait_cnt;
    logic              rdy_hit;
    logic              to_hit;

    // Ready is ignored in the first WAIT cycle so a stale resultRDY left over
    // from a previous op cannot complete this one; ready beats timeout.
    assign rdy_hit = (state == S_WAIT) && (wait_cnt != '0) && md_resultRDY;
    assign to_hit  = (state == S_WAIT) && !rdy_hit && (wait_cnt == WAIT_LAST);

    // Next-state, grant decision and request-side ready.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        grant_nxt  = grant_id;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req0_valid && (!req1_valid || !rr_ptr)) begin
                    req0_ready = 1'b1;
                    grant_nxt  = 1'b0;
                    accept     = 1'b1;
                    state_nxt  = S_START;
                end else if (req1_valid) begin
                    req1_ready = 1'b1;
                    grant_nxt  = 1'b1;
                    accept     = 1'b1;
                    state_nxt  = S_START;
                end
            end
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (rdy_hit || to_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Latch the winning op and rotate the round-robin pointer on accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            op_is_div <= 1'b0;
            grant_id  <= 1'b0;
            rr_ptr    <= 1'b0;
        end else if (accept) begin
            op_a      <= grant_nxt ? req1_opA    : req0_opA;
            op_b      <= grant_nxt ? req1_opB    : req0_opB;
            op_is_div <= grant_nxt ? req1_is_div : req0_is_div;
            grant_id  <= grant_nxt;
            rr_ptr    <= ~grant_nxt;
        end
    end

    // Wait counter: cleared in START, counts every WAIT cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 wait_cnt <= '0;
        else if (state == S_START) wait_cnt <= '0;
        else if (state == S_WAIT)  wait_cnt <= wait_cnt + CNT_W'(1);
    end

    // Response pulse and held result fields, captured on leaving WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp0_valid    <= 1'b0;
            resp1_valid    <= 1'b0;
            resp_result    <= '0;
            resp_exception <= 1'b0;
            resp_timeout   <= 1'b0;
        end else begin
            resp0_valid <= (rdy_hit || to_hit) && !grant_id;
            resp1_valid <= (rdy_hit || to_hit) && grant_id;
            if (rdy_hit) begin
                resp_result    <= md_result;
                resp_exception <= md_exception;
                resp_timeout   <= 1'b0;
            end else if (to_hit) begin
                resp_result    <= '0;
                resp_exception <= 1'b1;
                resp_timeout   <= 1'b1;
            end
        end
    end

    assign md_opA       = op_a;
    assign md_opB       = op_b;
    assign md_ctrl_MULT = (state == S_START) && !op_is_div;
    assign md_ctrl_DIV  = (state == S_START) && op_is_div;
    assign busy         = (state != S_IDLE);
    assign state_dbg    = state;

endmodule
